// File: rtl/clk_div_pkg.sv
// ---------------------------------------------------------------------------
// clk_div_pkg
// Shared definitions for the multi-channel clock divider:
//   DEFAULT_HP  - half-period value loaded into every channel at reset
//   ch_idx_w()  - width of a channel index, never less than one bit
//   chan_act_e  - per-cycle action taken by a divider channel
// ---------------------------------------------------------------------------
package clk_div_pkg;

  localparam int unsigned DEFAULT_HP = 30517;

  // A single-channel build still needs a one-bit select port.
  function automatic int ch_idx_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  typedef enum logic [1:0] {
    ACT_COUNT = 2'd0,  // mid half-period: advance the counter
    ACT_WRAP  = 2'd1,  // half-period complete: toggle level
    ACT_CLEAR = 2'd2   // sync or disabled: restart phase from zero
  } chan_act_e;

endpackage

// File: rtl/clk_divider_multi_if.sv
// ---------------------------------------------------------------------------
// clk_divider_multi_if
// Bundle of the divider control/status signals, for whoever drives a
// clk_divider_multi instance (sequencer, register block or bench).
//   en, sync, wr_en, wr_ch, wr_div : controller -> divider
//   div_clk, tick, pend            : divider -> controller
// ---------------------------------------------------------------------------
interface clk_divider_multi_if
  import clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 16
);

  localparam int unsigned CH_W = ch_idx_w(NUM_CH);

  logic [NUM_CH-1:0] en;
  logic              sync;
  logic              wr_en;
  logic [CH_W-1:0]   wr_ch;
  logic [CNT_W-1:0]  wr_div;
  logic [NUM_CH-1:0] div_clk;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] pend;

  modport master (
    output en, sync, wr_en, wr_ch, wr_div,
    input  div_clk, tick, pend
  );

  modport slave (
    input  en, sync, wr_en, wr_ch, wr_div,
    output div_clk, tick, pend
  );

endinterface

// File: rtl/clk_div_chan.sv
// ---------------------------------------------------------------------------
// clk_div_chan
// One divider channel: counts half-periods of HP+1 clk_i cycles and toggles
// a registered square wave, with a shadow register so a new divide value
// only takes effect on a phase boundary (wrap, sync or while disabled).
// Ports:
//   clk_i, reset     - system clock, synchronous active-high reset
//   en_i             - run enable (level)
//   sync_i           - phase restart pulse
//   wr_hit_i         - a write addressed to this channel this cycle
//   wr_div_i         - value being written
//   clk_o            - divided clock (register)
//   tick_o           - one-cycle strobe in the cycle clk_o rises (register)
//   pend_o           - written value waiting in the shadow (register)
// ---------------------------------------------------------------------------
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int unsigned      CNT_W    = 16,
  parameter logic [CNT_W-1:0] RESET_HP = '0
) (
  input  logic             clk_i,
  input  logic             reset,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             wr_hit_i,
  input  logic [CNT_W-1:0] wr_div_i,
  output logic             clk_o,
  output logic             tick_o,
  output logic             pend_o
);

  chan_act_e        act;
  logic             load;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] active_hp_q, active_hp_d;
  logic [CNT_W-1:0] shadow_hp_q, shadow_hp_d;
  logic             level_q, level_d;
  logic             tick_q, tick_d;
  logic             pend_q, pend_d;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    act     = ACT_COUNT;
    count_d = count_q + 1'b1;
    level_d = level_q;
    tick_d  = 1'b0;

    // Sync outranks the wrap compare, so a restart always wins.
    if (sync_i || !en_i) begin
      act = ACT_CLEAR;
    end else if (count_q == active_hp_q) begin
      act = ACT_WRAP;
    end

    case (act)
      ACT_CLEAR: begin
        count_d = '0;
        level_d = 1'b0;
      end
      ACT_WRAP: begin
        count_d = '0;
        level_d = ~level_q;
        tick_d  = ~level_q;  // strobe only on the rising half
      end
      default: ;
    endcase

    load = (act != ACT_COUNT);

    // shadow_hp_d already carries a same-cycle write, which gives the
    // write-bypass into active_hp for free.
    shadow_hp_d = wr_hit_i ? wr_div_i : shadow_hp_q;
    active_hp_d = load ? shadow_hp_d : active_hp_q;

    if (wr_hit_i) begin
      pend_d = !load;
    end else if (load) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (reset) begin
      count_q     <= '0;
      active_hp_q <= RESET_HP;
      shadow_hp_q <= RESET_HP;
      level_q     <= 1'b0;
      tick_q      <= 1'b0;
      pend_q      <= 1'b0;
    end else begin
      count_q     <= count_d;
      active_hp_q <= active_hp_d;
      shadow_hp_q <= shadow_hp_d;
      level_q     <= level_d;
      tick_q      <= tick_d;
      pend_q      <= pend_d;
    end
  end

  assign clk_o  = level_q;
  assign tick_o = tick_q;
  assign pend_o = pend_q;

endmodule

// File: rtl/clk_divider_multi.sv
// ---------------------------------------------------------------------------
// clk_divider_multi
// NUM_CH independent programmable clock dividers sharing one system clock.
// Ports:
//   clk_i     - system clock, all logic on its rising edge
//   reset     - synchronous active-high reset
//   en_i      - per-channel run enable
//   sync_i    - one-cycle pulse, phase-restarts every channel
//   wr_en_i   - divide-value write strobe
//   wr_ch_i   - channel addressed by the write (out-of-range is ignored)
//   wr_div_i  - half-period value HP (half-period = HP+1 cycles)
//   clk_o     - divided square wave per channel (register)
//   tick_o    - clock-enable strobe per channel, high as clk_o rises
//   pend_o    - per-channel shadow-pending flag
// clk_o is plain fabric logic; global buffering is left to the integrator.
// ---------------------------------------------------------------------------
(* keep_hierarchy = "yes" *)
module clk_divider_multi
  import clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned DEFAULT_HP = clk_div_pkg::DEFAULT_HP
) (
  input  logic                        clk_i,
  input  logic                        reset,
  input  logic [NUM_CH-1:0]           en_i,
  input  logic                        sync_i,
  input  logic                        wr_en_i,
  input  logic [ch_idx_w(NUM_CH)-1:0] wr_ch_i,
  input  logic [CNT_W-1:0]            wr_div_i,
  output logic [NUM_CH-1:0]           clk_o,
  output logic [NUM_CH-1:0]           tick_o,
  output logic [NUM_CH-1:0]           pend_o
);

  localparam int unsigned CH_W = ch_idx_w(NUM_CH);

  // Indices at or above NUM_CH match no channel, so those writes vanish.
  logic [NUM_CH-1:0] wr_hit;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign wr_hit[c] = wr_en_i && (wr_ch_i == CH_W'(c));

    clk_div_chan #(
      .CNT_W    (CNT_W),
      .RESET_HP (CNT_W'(DEFAULT_HP))
    ) u_chan (
      .clk_i    (clk_i),
      .reset    (reset),
      .en_i     (en_i[c]),
      .sync_i   (sync_i),
      .wr_hit_i (wr_hit[c]),
      .wr_div_i (wr_div_i),
      .clk_o    (clk_o[c]),
      .tick_o   (tick_o[c]),
      .pend_o   (pend_o[c])
    );
  end

endmodule

// File: tb/tb_clk_divider_multi.sv
// ---------------------------------------------------------------------------
// tb_clk_divider_multi
// Directed bench for clk_divider_multi with NUM_CH=3, CNT_W=4, DEFAULT_HP=3.
// Vector records hold the inputs for a run of identical cycles and the
// outputs expected after each of those clock edges.
// ---------------------------------------------------------------------------
module tb_clk_divider_multi;

  localparam int unsigned NUM_CH = 3;
  localparam int unsigned CNT_W  = 4;

  logic clk;
  logic reset;

  clk_divider_multi_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

  clk_divider_multi #(
    .NUM_CH     (NUM_CH),
    .CNT_W      (CNT_W),
    .DEFAULT_HP (3)
  ) dut (
    .clk_i    (clk),
    .reset    (reset),
    .en_i     (bus.en),
    .sync_i   (bus.sync),
    .wr_en_i  (bus.wr_en),
    .wr_ch_i  (bus.wr_ch),
    .wr_div_i (bus.wr_div),
    .clk_o    (bus.div_clk),
    .tick_o   (bus.tick),
    .pend_o   (bus.pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         n;
    logic       rst;
    logic [2:0] en;
    logic       sync;
    logic       we;
    logic [1:0] wch;
    logic [3:0] wdiv;
    logic [2:0] eclk;
    logic [2:0] etick;
    logic [2:0] epend;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec=%0d got=%0h want=%0h at %0t", name, idx, act, exp, $time);
    end
  endtask

  function automatic void add(input int n, input logic rst, input logic [2:0] en,
                              input logic sync, input logic we, input logic [1:0] wch,
                              input logic [3:0] wdiv, input logic [2:0] eclk,
                              input logic [2:0] etick, input logic [2:0] epend);
    vec_t v;
    v.n = n; v.rst = rst; v.en = en; v.sync = sync; v.we = we; v.wch = wch;
    v.wdiv = wdiv; v.eclk = eclk; v.etick = etick; v.epend = epend;
    vecs.push_back(v);
  endfunction

  task automatic drive(input logic rst, input logic [2:0] en, input logic sync,
                       input logic we, input logic [1:0] wch, input logic [3:0] wdiv);
    reset      = rst;
    bus.en     = en;
    bus.sync   = sync;
    bus.wr_en  = we;
    bus.wr_ch  = wch;
    bus.wr_div = wdiv;
  endtask

  initial begin
    int   rise_at;
    int   period;
    logic rise_tick;

    drive(1'b1, 3'b000, 1'b0, 1'b0, 2'd0, 4'd0);

    //  n  rst en     syn we ch div   clk     tick    pend
    // reset state
    add(2, 1, 3'b000, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000);
    // ch0 default HP=3: rises after 4 cycles, period 8
    add(3, 0, 3'b001, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000);
    add(1, 0, 3'b001, 0, 0, 0, 0, 3'b001, 3'b001, 3'b000);
    add(3, 0, 3'b001, 0, 0, 0, 0, 3'b001, 3'b000, 3'b000);
    add(4, 0, 3'b001, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000);
    add(1, 0, 3'b001, 0, 0, 0, 0, 3'b001, 3'b001, 3'b000);
    add(3, 0, 3'b001, 0, 0, 0, 0, 3'b001, 3'b000, 3'b000);
    add(1, 0, 3'b001, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000);
    // write HP=5 at count=1: current half stays 4, pend until wrap
    add(1, 0, 3'b001, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000);
    add(1, 0, 3'b001, 0, 1, 0, 5, 3'b000, 3'b000, 3'b001);
    add(1, 0, 3'b001, 0, 0, 0, 0, 3'b000, 3'b000, 3'b001);
    add(1, 0, 3'b001, 0, 0, 0, 0, 3'b001, 3'b001, 3'b000);
    add(5, 0, 3'b001, 0, 0, 0, 0, 3'b001, 3'b000, 3'b000);
    add(6, 0, 3'b001, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000);
    add(1, 0, 3'b001, 0, 0, 0, 0, 3'b001, 3'b001, 3'b000);
    // out-of-range channel write is ignored
    add(1, 0, 3'b001, 0, 1, 3, 0, 3'b001, 3'b000, 3'b000);
    add(4, 0, 3'b001, 0, 0, 0, 0, 3'b001, 3'b000, 3'b000);
    add(1, 0, 3'b001, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000);
    // ch1 HP=0 written while disabled (bypass, no pend), then clk/2
    add(1, 0, 3'b000, 0, 1, 1, 0, 3'b000, 3'b000, 3'b000);
    add(1, 0, 3'b010, 0, 0, 0, 0, 3'b010, 3'b010, 3'b000);
    add(1, 0, 3'b010, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000);
    add(1, 0, 3'b010, 0, 0, 0, 0, 3'b010, 3'b010, 3'b000);
    add(1, 0, 3'b010, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000);
    // ch0 back to HP=3 while disabled; ch2 gets a 2-cycle head start
    add(1, 0, 3'b000, 0, 1, 0, 3, 3'b000, 3'b000, 3'b000);
    add(2, 0, 3'b100, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000);
    add(1, 0, 3'b111, 0, 0, 0, 0, 3'b010, 3'b010, 3'b000);
    add(1, 0, 3'b111, 0, 0, 0, 0, 3'b100, 3'b100, 3'b000);
    // sync at ch0 count=2: all restart, ch0/ch2 then edge-aligned
    add(1, 0, 3'b111, 1, 0, 0, 0, 3'b000, 3'b000, 3'b000);
    add(1, 0, 3'b111, 0, 0, 0, 0, 3'b010, 3'b010, 3'b000);
    add(1, 0, 3'b111, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000);
    add(1, 0, 3'b111, 0, 0, 0, 0, 3'b010, 3'b010, 3'b000);
    add(1, 0, 3'b111, 0, 0, 0, 0, 3'b101, 3'b101, 3'b000);
    add(1, 0, 3'b111, 0, 0, 0, 0, 3'b111, 3'b010, 3'b000);
    // pending write then reset held 3 cycles
    add(1, 0, 3'b111, 0, 1, 0, 7, 3'b101, 3'b000, 3'b001);
    add(3, 1, 3'b111, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000);

    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].n; k++) begin
        drive(vecs[i].rst, vecs[i].en, vecs[i].sync,
              vecs[i].we, vecs[i].wch, vecs[i].wdiv);
        @(posedge clk);
        #1;
        check("clk_o",  i, 32'(bus.div_clk), 32'(vecs[i].eclk));
        check("tick_o", i, 32'(bus.tick),    32'(vecs[i].etick));
        check("pend_o", i, 32'(bus.pend),    32'(vecs[i].epend));
      end
    end

    // After reset the discarded HP=7 must not apply: rise after 4, period 8.
    drive(1'b0, 3'b001, 1'b0, 1'b0, 2'd0, 4'd0);
    rise_at   = -1;
    rise_tick = 1'b0;
    for (int i = 1; i <= 20 && rise_at < 0; i++) begin
      @(posedge clk);
      #1;
      if (bus.div_clk[0]) begin
        rise_at   = i;
        rise_tick = bus.tick[0];
      end
    end
    check("rise_after_reset", 0, 32'(rise_at), 32'd4);
    check("tick_at_rise", 0, 32'(rise_tick), 32'd1);

    period = -1;
    for (int i = 1; i <= 20 && period < 0; i++) begin
      @(posedge clk);
      #1;
      if (bus.tick[0]) period = i;
    end
    check("period_after_reset", 0, 32'(period), 32'd8);
    check("idle_channels", 0, 32'(bus.div_clk[2:1]), 32'd0);
    check("pend_after_reset", 0, 32'(bus.pend), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
